// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared definitions for the data-cache refill controller: default geometry,
// beat-counter sizing and the refill FSM state encodings.
package dcache_refill_ctrl_pkg;

  localparam int WORD_SIZE        = 32;   // byte-address width
  localparam int BLOCK_SIZE       = 256;  // cache line width in bits
  localparam int CACHE_OFFSET_LEN = 5;    // byte offset bits within a line
  localparam int BLOCK_WORDS      = 8;    // memory beats per line
  localparam int BEAT_CNT_LEN     = 3;    // log2(BLOCK_WORDS)

  typedef enum logic [2:0] {
    REFILL_IDLE  = 3'd0,
    REFILL_WB    = 3'd1,
    REFILL_RD    = 3'd2,
    REFILL_DRAIN = 3'd3,
    REFILL_RESP  = 3'd4
  } refill_state_e;

endpackage

// File: rtl/dcache_refill_ctrl.sv
// Refill controller: turns one cache miss (optional dirty writeback plus
// optional line fill) into word-wide memory beats and returns the filled line.
// Word 0 of a line sits in the MSBs; beat k targets {line_addr, k, 2'b00}.
module dcache_refill_ctrl
  import dcache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = WORD_SIZE,
  parameter int WORD_W = 32,
  parameter int LINE_W = BLOCK_SIZE,
  parameter int BEATS  = BLOCK_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_evict,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] req_evict_addr,
  input  logic [LINE_W-1:0] req_evict_data,
  input  logic [ADDR_W-1:0] req_fill_addr,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int CNT_W  = $clog2(BEATS);
  localparam int BYTE_W = $clog2(WORD_W / 8);
  localparam int OFF_W  = CNT_W + BYTE_W;
  localparam int LN_W   = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  // Element BEATS-1 is word 0 (MSBs), element 0 is the last word.
  typedef logic [BEATS-1:0][WORD_W-1:0] line_t;

  refill_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             fill_q;
  logic [LN_W-1:0]  ev_ln_q;
  logic [LN_W-1:0]  fl_ln_q;
  line_t            ev_line_q;
  line_t            stage_q;
  line_t            resp_q;
  line_t            req_line;
  logic             cap_vld;      // a read beat was issued last cycle
  logic [CNT_W-1:0] cap_idx;      // which word that beat carries

  // Byte offset bits of the request addresses are intentionally dropped.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{req_evict_addr[OFF_W-1:0], req_fill_addr[OFF_W-1:0]};

  assign req_line  = req_evict_data;
  assign req_ready = (state == REFILL_IDLE);
  assign resp_data = resp_q;
  assign cnt_nxt   = cnt + CNT_W'(1);

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [LN_W-1:0] ln,
                                                  input logic [CNT_W-1:0] k);
    return {ln, k, {BYTE_W{1'b0}}};
  endfunction

  // Miss sequencing: accept, write back victim beats, issue read beats,
  // drain the last read, then pulse the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REFILL_IDLE;
      cnt        <= '0;
      fill_q     <= 1'b0;
      ev_ln_q    <= '0;
      fl_ln_q    <= '0;
      ev_line_q  <= '0;
      resp_q     <= '0;
      resp_valid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
    end else begin
      resp_valid <= 1'b0;
      cap_vld    <= 1'b0;
      unique case (state)
        REFILL_IDLE: begin
          if (req_valid) begin
            cnt       <= '0;
            fill_q    <= req_fill;
            ev_ln_q   <= req_evict_addr[ADDR_W-1:OFF_W];
            fl_ln_q   <= req_fill_addr[ADDR_W-1:OFF_W];
            ev_line_q <= req_line;
            if (req_evict) begin
              state     <= REFILL_WB;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= beat_addr(req_evict_addr[ADDR_W-1:OFF_W], '0);
              mem_wdata <= req_line[BEATS-1];
            end else if (req_fill) begin
              state    <= REFILL_RD;
              mem_en   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= beat_addr(req_fill_addr[ADDR_W-1:OFF_W], '0);
            end else begin
              state      <= REFILL_RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        REFILL_WB: begin
          if (cnt == LAST) begin
            mem_we <= 1'b0;
            if (fill_q) begin
              state    <= REFILL_RD;
              cnt      <= '0;
              mem_addr <= beat_addr(fl_ln_q, '0);
            end else begin
              state      <= REFILL_RESP;
              mem_en     <= 1'b0;
              resp_valid <= 1'b1;
            end
          end else begin
            cnt       <= cnt_nxt;
            mem_addr  <= beat_addr(ev_ln_q, cnt_nxt);
            mem_wdata <= ev_line_q[LAST - cnt_nxt];
          end
        end
        REFILL_RD: begin
          cap_vld <= 1'b1;
          cap_idx <= cnt;
          if (cnt == LAST) begin
            state  <= REFILL_DRAIN;
            mem_en <= 1'b0;
          end else begin
            cnt      <= cnt_nxt;
            mem_addr <= beat_addr(fl_ln_q, cnt_nxt);
          end
        end
        REFILL_DRAIN: begin
          // Last word arrives this cycle; publish the line directly.
          resp_q     <= {stage_q[BEATS-1:1], mem_rdata};
          resp_valid <= 1'b1;
          state      <= REFILL_RESP;
        end
        REFILL_RESP: begin
          state <= REFILL_IDLE;
        end
        default: state <= REFILL_IDLE;
      endcase
    end
  end

  // Line assembly: each read word lands one cycle after its beat was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else if (cap_vld) begin
      stage_q[LAST - cap_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: a backing memory, a
// transaction-level reference model and a per-cycle output compare.
module tb_dcache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_evict = 1'b0;
  logic         req_fill = 1'b0;
  logic [31:0]  req_evict_addr = '0;
  logic [255:0] req_evict_data = '0;
  logic [31:0]  req_fill_addr = '0;
  logic         resp_valid;
  logic [255:0] resp_data;
  logic         mem_en;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  dcache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_evict(req_evict), .req_fill(req_fill),
    .req_evict_addr(req_evict_addr), .req_evict_data(req_evict_data),
    .req_fill_addr(req_fill_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Unwritten memory word at byte address a: 0x1000_0000 at 0x40, +1 per word.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]} - 32'd16;
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a, input int k);
    return {a[31:5], 5'b0} + 32'(k * 4);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Backing memory driven by the DUT.
  logic [31:0] mem    [logic [29:0]];
  logic [31:0] shadow [logic [29:0]];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[31:2]] = mem_wdata;
      else mem_rdata <= mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]] : dflt(mem_addr);
    end
  end

  // Reference model: one transaction at a time, outputs derived from the
  // cycle offset since acceptance.
  bit           busy = 1'b0;
  bit           m_ev, m_fl;
  int           t_acc, wb_n, resp_off;
  logic [31:0]  m_ea, m_fa;
  logic [255:0] m_eline, m_line;
  logic         e_ready = 1'b1, e_en = 1'b0, e_we = 1'b0, e_rv = 1'b0;
  logic [31:0]  e_addr = '0, e_wdata = '0;
  logic [255:0] e_rd = '0;

  always @(posedge clk) begin : model
    int c, j;
    logic [31:0] a;
    c = cyc;
    if (rst) begin
      busy = 1'b0;
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_rv = 1'b0; e_rd = '0;
    end else begin
      if (busy) begin
        if (c - t_acc == resp_off) busy = 1'b0;
      end else if (req_valid) begin
        busy = 1'b1; t_acc = c;
        m_ev = req_evict; m_fl = req_fill;
        m_ea = req_evict_addr; m_fa = req_fill_addr; m_eline = req_evict_data;
        wb_n = m_ev ? 8 : 0;
        resp_off = m_fl ? wb_n + 10 : (m_ev ? 9 : 1);
        if (m_ev)
          for (int k = 0; k < 8; k++) shadow[baddr(m_ea, k) >> 2] = m_eline[255-32*k -: 32];
        if (m_fl)
          for (int k = 0; k < 8; k++) begin
            a = baddr(m_fa, k);
            m_line[255-32*k -: 32] = shadow.exists(a[31:2]) ? shadow[a[31:2]] : dflt(a);
          end
      end
      e_en = 1'b0; e_we = 1'b0; e_rv = 1'b0;
      if (busy) begin
        j = c + 1 - t_acc;
        if (j <= wb_n) begin
          e_en = 1'b1; e_we = 1'b1;
          e_addr = baddr(m_ea, j - 1);
          e_wdata = m_eline[255-32*(j-1) -: 32];
        end else if (m_fl && j <= wb_n + 8) begin
          e_en = 1'b1;
          e_addr = baddr(m_fa, j - wb_n - 1);
        end
        if (j == resp_off) begin
          e_rv = 1'b1;
          if (m_fl) e_rd = m_line;
        end
      end
    end
    e_ready = !busy;
    cyc = c + 1;
    started = 1'b1;
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", 256'(req_ready), 256'(e_ready));
      chk("mem_en", 256'(mem_en), 256'(e_en));
      if (e_en) chk("mem_we", 256'(mem_we), 256'(e_we));
      chk("mem_addr", 256'(mem_addr), 256'(e_addr));
      chk("mem_wdata", 256'(mem_wdata), 256'(e_wdata));
      chk("resp_valid", 256'(resp_valid), 256'(e_rv));
      chk("resp_data", resp_data, e_rd);
    end
  end

  // Issue one request when idle; returns at the negedge after acceptance.
  task automatic txn(input bit ev, input bit fl, input logic [31:0] ea,
                     input logic [255:0] ed, input logic [31:0] fa, output int t);
    int g;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout cycle %0d: got 0 expected 1", cyc);
    end
    req_valid = 1'b1; req_evict = ev; req_fill = fl;
    req_evict_addr = ea; req_evict_data = ed; req_fill_addr = fa;
    t = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_evict = 1'b1; req_fill = 1'b1;
    req_evict_addr = 32'hDEAD_BEE0; req_evict_data = {8{32'hFFFF_0000}}; req_fill_addr = 32'hBAD0_0000;
  endtask

  task automatic wait_resp(input int t, output int lat);
    int g;
    g = 0;
    while (!resp_valid && g < 40) begin @(negedge clk); g++; end
    if (!resp_valid) begin
      checks++; errors++; lat = -1;
      $display("FAIL resp_timeout cycle %0d: got 0 expected 1", cyc);
    end else lat = cyc - t;
  endtask

  logic [255:0] line_a, line_b, line_c;
  int t, lat, tb2;

  initial begin
    for (int k = 0; k < 8; k++) begin
      line_a[255-32*k -: 32] = 32'hA0 + 32'(k);
      line_b[255-32*k -: 32] = 32'hB0 + 32'(k);
      line_c[255-32*k -: 32] = 32'hC0 + 32'(k);
    end
    repeat (3) @(negedge clk);
    chk("reset_ready", 256'(req_ready), 256'(1));
    chk("reset_mem_en", 256'(mem_en), 256'(0));
    chk("reset_resp_valid", 256'(resp_valid), 256'(0));
    chk("reset_resp_data", resp_data, 256'(0));
    rst = 1'b0;

    // Fill only at 0x40
    txn(1'b0, 1'b1, 32'h0, '0, 32'h40, t);
    chk("fill_first_addr", 256'(mem_addr), 256'(32'h40));
    chk("fill_first_en", 256'(mem_en), 256'(1));
    wait_resp(t, lat);
    chk("fill_latency", 256'(lat), 256'(10));
    chk("fill_word0", 256'(resp_data[255:224]), 256'(32'h1000_0000));
    chk("fill_word7", 256'(resp_data[31:0]), 256'(32'h1000_0007));
    chk("model_word0", 256'(e_rd[255:224]), 256'(32'h1000_0000));

    // Evict 0x80 + fill 0x100
    txn(1'b1, 1'b1, 32'h80, line_a, 32'h100, t);
    chk("wb_first_addr", 256'(mem_addr), 256'(32'h80));
    chk("wb_first_data", 256'(mem_wdata), 256'(32'hA0));
    chk("wb_first_we", 256'(mem_we), 256'(1));
    wait_resp(t, lat);
    chk("evfill_latency", 256'(lat), 256'(18));
    chk("evfill_word0", 256'(resp_data[255:224]), 256'(32'h1000_0030));

    // Evict and fill the same line
    txn(1'b1, 1'b1, 32'h60, line_b, 32'h60, t);
    wait_resp(t, lat);
    chk("same_line_latency", 256'(lat), 256'(18));
    chk("same_line_data", resp_data, line_b);

    // Evict only: resp_data keeps the last fill
    txn(1'b1, 1'b0, 32'h1A0, line_c, 32'h0, t);
    wait_resp(t, lat);
    chk("evict_latency", 256'(lat), 256'(9));
    chk("evict_resp_hold", resp_data, line_b);

    // Neither flag
    txn(1'b0, 1'b0, 32'h0, '0, 32'h0, t);
    chk("noop_no_mem", 256'(mem_en), 256'(0));
    wait_resp(t, lat);
    chk("noop_latency", 256'(lat), 256'(1));
    chk("noop_resp_hold", resp_data, line_b);

    // Reset in the middle of a fill
    txn(1'b0, 1'b1, 32'h0, '0, 32'h40, t);
    while (cyc < t + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_en", 256'(mem_en), 256'(0));
    chk("midrst_ready", 256'(req_ready), 256'(1));
    chk("midrst_resp_valid", 256'(resp_valid), 256'(0));
    chk("midrst_resp_data", resp_data, 256'(0));
    rst = 1'b0;
    txn(1'b0, 1'b1, 32'h0, '0, 32'h40, t);
    wait_resp(t, lat);
    chk("postrst_latency", 256'(lat), 256'(10));
    chk("postrst_word7", 256'(resp_data[31:0]), 256'(32'h1000_0007));

    // Back-to-back with req_valid held; 0x5F aliases the 0x40 line
    @(negedge clk);
    req_valid = 1'b1; req_evict = 1'b0; req_fill = 1'b1; req_fill_addr = 32'h5F;
    t = cyc;
    @(negedge clk);
    req_fill_addr = 32'h100;
    wait_resp(t, lat);
    chk("b2b_first_latency", 256'(lat), 256'(10));
    chk("alias_word0", 256'(resp_data[255:224]), 256'(32'h1000_0000));
    chk("alias_word7", 256'(resp_data[31:0]), 256'(32'h1000_0007));
    @(negedge clk);
    chk("b2b_ready_after_resp", 256'(req_ready), 256'(1));
    tb2 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(tb2, lat);
    chk("b2b_second_latency", 256'(lat), 256'(10));
    chk("b2b_second_word0", 256'(resp_data[255:224]), 256'(32'h1000_0030));

    // Randomized traffic, checked only by the per-cycle compare
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 2) != 0);
      req_evict = 1'($urandom_range(0, 1));
      req_fill  = 1'($urandom_range(0, 1));
      req_evict_addr = 32'($urandom_range(0, 15) * 32 + $urandom_range(0, 31));
      req_fill_addr  = 32'($urandom_range(0, 15) * 32 + $urandom_range(0, 31));
      for (int k = 0; k < 8; k++) req_evict_data[255-32*k -: 32] = $urandom;
    end
    @(negedge clk);
    req_valid = 1'b0;
    begin
      int g;
      g = 0;
      while (!req_ready && g < 40) begin @(negedge clk); g++; end
    end
    chk("final_idle", 256'(req_ready), 256'(1));
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d: got running expected finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
